// File: rtl/sd_encr_host_if.sv
// Host byte-channel front end for the SD XOR encryptor: key loading, encrypt/decrypt
// sequencing with a done timeout, and a one-byte status response.
module sd_encr_host_if #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int HALF_BYTES     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   resp_data,
  output logic         resp_valid,
  input  logic         resp_ready,
  input  logic         sd_ready,
  input  logic         done,
  output logic         start,
  output logic         rw_flag,
  output logic         key_rw,
  output logic         key_sel,
  output logic [511:0] key_data_in,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(HALF_BYTES);

  localparam logic [7:0] OP_KEY = 8'h4B;
  localparam logic [7:0] OP_ENC = 8'h45;
  localparam logic [7:0] OP_DEC = 8'h44;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BAD_OP  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE, KEY_RX, KEY_WR, CMD_ARM, CMD_WAIT, RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          half;
  logic [TW-1:0] tcnt;
  logic          in_fire;

  assign in_fire = in_valid && in_ready;

  // start must coincide with the first cycle the device reports ready
  assign start = (state == CMD_ARM) && sd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      half        <= 1'b0;
      tcnt        <= '0;
      in_ready    <= 1'b0;
      resp_data   <= 8'h00;
      resp_valid  <= 1'b0;
      rw_flag     <= 1'b0;
      key_rw      <= 1'b0;
      key_sel     <= 1'b0;
      key_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            busy <= 1'b1;
            case (in_data)
              OP_KEY: begin
                state <= KEY_RX;
                cnt   <= '0;
                half  <= 1'b0;
              end
              OP_ENC, OP_DEC: begin
                state    <= CMD_ARM;
                rw_flag  <= (in_data == OP_ENC);
                in_ready <= 1'b0;
              end
              default: begin
                state      <= RESP;
                resp_data  <= ST_BAD_OP;
                resp_valid <= 1'b1;
                in_ready   <= 1'b0;
              end
            endcase
          end
        end

        KEY_RX: begin
          if (in_fire) begin
            // shifting in from the top leaves the first byte of the half at the LSB
            key_data_in <= {in_data, key_data_in[511:8]};
            if (cnt == CW'(HALF_BYTES - 1)) begin
              state    <= KEY_WR;
              in_ready <= 1'b0;
              key_rw   <= 1'b1;
              key_sel  <= half;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        KEY_WR: begin
          key_rw <= 1'b0;
          if (!half) begin
            state    <= KEY_RX;
            half     <= 1'b1;
            cnt      <= '0;
            in_ready <= 1'b1;
          end else begin
            state      <= RESP;
            resp_data  <= ST_OK;
            resp_valid <= 1'b1;
          end
        end

        CMD_ARM: begin
          if (sd_ready) begin
            state <= CMD_WAIT;
            tcnt  <= '0;
          end
        end

        CMD_WAIT: begin
          // done takes priority over a timeout landing on the same cycle
          if (done) begin
            state      <= RESP;
            resp_data  <= ST_OK;
            resp_valid <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state      <= RESP;
              resp_data  <= ST_TIMEOUT;
              resp_valid <= 1'b1;
            end
          end
        end

        RESP: begin
          if (resp_valid && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready   <= 1'b0;
          resp_valid <= 1'b0;
          key_rw     <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
